// File: rtl/ctrl_mc_wait.sv
// ctrl_mc_wait: multicycle SISC control FSM with memory wait/timeout, resumable HALT and retire counter.
// Optional FAST_ALU_EN: ALU ops skip the MEM state (EXECUTE -> WRITEBACK).
module ctrl_mc_wait #(
    parameter int OP_W     = 4,
    parameter int CC_W     = 4,
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15,
    parameter int IMM_MM   = 8
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic [OP_W-1:0]  opcode,
    input  logic [CC_W-1:0]  mm,
    input  logic [CC_W-1:0]  stat,
    input  logic             mem_ack,
    input  logic             resume,
    output logic             pc_rst,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             br_sel,
    output logic             ir_load,
    output logic             rb_sel,
    output logic [1:0]       alu_op,
    output logic [1:0]       wb_sel,
    output logic             rf_we,
    output logic             dm_we,
    output logic             mem_req,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] instr_cnt
);
    typedef enum logic [2:0] {START, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT} state_t;
    localparam logic [3:0] LOD = 4'd1, STR = 4'd2, SWP = 4'd3, BRA = 4'd4, BRR = 4'd5,
                           BNE = 4'd6, BNR = 4'd7, ALU = 4'd8, HLT = 4'd15;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CC_W-1:0] IMM = CC_W'(IMM_MM);
    state_t state, state_n;
    logic [3:0] op_d, op_q;
    logic [CC_W-1:0] mm_q;
    logic [WW-1:0] wcnt;
    logic taken, retire, timeout;
    // illegal opcodes (nonzero upper bits) fold to NOOP before anything sees them
    assign op_d = ((opcode >> 4) != '0) ? 4'd0 : opcode[3:0];
    always_ff @(posedge clk) begin
        if (rst_f) begin
            state     <= START;
            instr_cnt <= '0;
            mem_err   <= 1'b0;
            wcnt      <= '0;
            op_q      <= '0;
            mm_q      <= '0;
        end else begin
            state <= state_n;
            if (state == DECODE) begin
                op_q <= op_d;
                mm_q <= mm;
            end
            if (retire)
                instr_cnt <= instr_cnt + 1'b1;
            if (timeout)
                mem_err <= 1'b1;
            wcnt <= (state == MEM && state_n == MEM) ? wcnt + 1'b1 : '0;
        end
    end
    always_comb begin
        state_n  = state;
        pc_rst   = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        ir_load  = 1'b0;
        rb_sel   = 1'b0;
        alu_op   = 2'b00;
        wb_sel   = 2'b00;
        rf_we    = 1'b0;
        dm_we    = 1'b0;
        mem_req  = 1'b0;
        halted   = 1'b0;
        taken    = 1'b0;
        retire   = 1'b0;
        timeout  = 1'b0;
        case (state)
            START: begin
                pc_rst  = 1'b1;
                state_n = FETCH;
            end
            FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                state_n  = DECODE;
            end
            DECODE: begin
                taken    = (op_d == BRA || op_d == BRR) ? |(stat & mm) :
                           (op_d == BNE || op_d == BNR) ? ~|(stat & mm) : 1'b0;
                pc_write = taken;
                pc_sel   = taken;
                br_sel   = taken && (op_d == BRA || op_d == BNE);
                rb_sel   = op_d == STR || op_d == SWP;
                state_n  = op_d == HLT ? HALT : (op_d inside {LOD, STR, SWP, ALU}) ? EXECUTE : FETCH;
                retire   = state_n == FETCH;
            end
            EXECUTE: begin
                alu_op = op_q == ALU ? {1'b0, mm_q == IMM} :
                         (op_q == LOD || op_q == STR) ? {1'b1, mm_q == IMM} : 2'b00;
`ifdef FAST_ALU_EN
                state_n = op_q == ALU ? WRITEBACK : MEM;
`else
                state_n = MEM;
`endif
            end
            MEM: begin
                // ALU ops only pass through here; they never wait on mem_ack
                mem_req = op_q != ALU;
                dm_we   = op_q == STR;
                timeout = mem_req && !mem_ack && wcnt == WW'(MAX_WAIT - 1);
                state_n = (!mem_req || mem_ack) ? WRITEBACK : timeout ? FETCH : MEM;
            end
            WRITEBACK: begin
                rf_we   = op_q != STR;
                wb_sel  = op_q == LOD ? 2'd1 : op_q == SWP ? 2'd2 : 2'd0;
                retire  = 1'b1;
                state_n = FETCH;
            end
            HALT: begin
                halted  = 1'b1;
                retire  = resume;
                state_n = resume ? FETCH : HALT;
            end
            default: state_n = START;
        endcase
    end
endmodule
